seq_det_param: RTL and testbench

- Parametrised Mealy bit-serial sequence detector; next generation of the fixed-pattern "1011" detector.
- Pattern and length are programmable at run time, up to MAX_LEN bits.
- Runtime selectable overlapping or non-overlapping detection; input-valid qualifier; saturating match counter.
- Sits on a serial data path; the sd_o pulse feeds downstream framing/sync logic.

---
 rtl/seq_det_param.sv | 110 +++++++++++
 tb/tb_seq_det_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_param
// Brief    : Run-time programmable Mealy bit-serial sequence detector with
//            overlap control, valid qualifier and saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0000_1011,
  parameter int                 RST_LEN = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         d_i,
  input  logic                         valid_i,
  input  logic                         cfg_we_i,
  input  logic [MAX_LEN-1:0]           pat_i,
  input  logic [$clog2(MAX_LEN+1)-1:0] len_i,
  input  logic                         mode_i,
  input  logic                         cnt_clr_i,
  output logic                         sd_o,
  output logic [CNT_W-1:0]             match_cnt_o,
  output logic                         busy_o
);

  localparam int                 c_len_w    = $clog2(MAX_LEN + 1);
  localparam logic [c_len_w-1:0] c_fill_max = c_len_w'(MAX_LEN - 1);
  localparam logic [c_len_w-1:0] c_max_len  = c_len_w'(MAX_LEN);
  localparam logic [c_len_w-1:0] c_one      = c_len_w'(1);

  logic [MAX_LEN-1:0] r_pat;
  logic [c_len_w-1:0] r_len;
  logic               r_mode;
  logic [MAX_LEN-2:0] r_hist;
  logic [c_len_w-1:0] r_fill;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-2:0] w_hist_nxt;
  logic [MAX_LEN-1:0] w_win;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_accept;
  logic               w_len_ok;
  logic               w_fill_ok;
  logic               w_pat_eq;
  logic               w_hit;

  if (MAX_LEN > 2) begin : g_hist_wide
    assign w_hist_nxt = {r_hist[MAX_LEN-3:0], d_i};
  end else begin : g_hist_narrow
    assign w_hist_nxt = d_i;
  end

  // Window is the newest MAX_LEN bits ending with the current d_i; only the
  // low len bits take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_win     = {r_hist, d_i};
  assign w_pat_eq  = (((w_win ^ r_pat) & w_mask) == '0);
  assign w_accept  = valid_i & ~cfg_we_i;
  assign w_len_ok  = (r_len != '0) && (r_len <= c_max_len);
  assign w_fill_ok = (r_fill >= (r_len - c_one));
  assign w_hit     = w_accept & w_len_ok & w_fill_ok & w_pat_eq;

  assign sd_o        = w_hit & rst_ni;
  assign match_cnt_o = r_cnt;
  assign busy_o      = (r_fill != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pat  <= RST_PAT;
      r_len  <= c_len_w'(RST_LEN);
      r_mode <= 1'b0;
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_we_i) begin
      r_pat  <= pat_i;
      r_len  <= len_i;
      r_mode <= mode_i;
      r_hist <= '0;
      r_fill <= '0;
    end else if (valid_i) begin
      r_hist <= w_hist_nxt;
      // Non-overlapping mode forgets the bits that formed the match.
      if (w_hit && !r_mode) begin
        r_fill <= '0;
      end else if (r_fill != c_fill_max) begin
        r_fill <= r_fill + c_one;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_cnt <= '0;
    end else if (w_hit && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_param
// Brief    : Scoreboard bench for seq_det_param (8-bit and 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_param;

  typedef struct {
    int sd;
    int cnt_a;
    int cnt_b;
    int busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d = 1'b0, valid = 1'b0, cfg_we = 1'b0, mode_in = 1'b0, cnt_clr = 1'b0;
  logic [7:0] pat_in = '0;
  logic [3:0] len_in = '0;
  logic       sd_a, busy_a, sd_b, busy_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_chk = 0;
  int n_fail = 0;
  exp_t expq[$];

  // reference model state
  bit         mh[$];
  int         avail;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_mode;
  int         m_cnt_a, m_cnt_b;

  always #5 clk = ~clk;

  seq_det_param #(.MAX_LEN(8), .CNT_W(8)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .d_i(d), .valid_i(valid), .cfg_we_i(cfg_we),
    .pat_i(pat_in), .len_i(len_in), .mode_i(mode_in), .cnt_clr_i(cnt_clr),
    .sd_o(sd_a), .match_cnt_o(cnt_a), .busy_o(busy_a)
  );

  seq_det_param #(.MAX_LEN(8), .CNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .d_i(d), .valid_i(valid), .cfg_we_i(cfg_we),
    .pat_i(pat_in), .len_i(len_in), .mode_i(mode_in), .cnt_clr_i(cnt_clr),
    .sd_o(sd_b), .match_cnt_o(cnt_b), .busy_o(busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh.delete();
    avail   = 0;
    m_pat   = 8'b0000_1011;
    m_len   = 4;
    m_mode  = 0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  // Match if the last len accepted-and-unconsumed bits plus d equal the pattern,
  // pattern bit k being the bit received k cycles before the current one.
  function automatic bit model_hit(input bit dd, input bit vv, input bit we);
    if (!vv || we) return 0;
    if (m_len < 1 || m_len > 8) return 0;
    if (avail < m_len - 1) return 0;
    for (int k = 0; k < m_len; k++) begin
      bit b;
      b = (k == 0) ? dd : mh[mh.size() - k];
      if (b != m_pat[k]) return 0;
    end
    return 1;
  endfunction

  task automatic step(input bit dd, input bit vv, input bit we, input logic [7:0] p,
                      input logic [3:0] l, input bit m, input bit clr);
    exp_t e;
    bit   hit;
    @(posedge clk);
    #1;
    d = dd; valid = vv; cfg_we = we; pat_in = p; len_in = l; mode_in = m; cnt_clr = clr;
    hit     = model_hit(dd, vv, we);
    e.sd    = int'(hit);
    e.cnt_a = m_cnt_a;
    e.cnt_b = m_cnt_b;
    e.busy  = (avail != 0) ? 1 : 0;
    expq.push_back(e);
    if (we) begin
      m_pat = p; m_len = int'(l); m_mode = m; mh.delete(); avail = 0;
    end else if (vv) begin
      mh.push_back(dd);
      if (mh.size() > 7) void'(mh.pop_front());
      if (hit && !m_mode) avail = 0;
      else if (avail < 7) avail++;
    end
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (hit) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
  endtask

  task automatic send(input bit dd);
    step(dd, 1, 0, 8'h00, 4'd0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 4'd0, 0, 0);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit m);
    step(bit'($urandom_range(0, 1)), 1, 1, p, l, m, 0);
  endtask

  task automatic send_word(input logic [7:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send(w[i]);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sd_a", int'(sd_a), 0);
    chk("rst_sd_b", int'(sd_b), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_cnt_b", int'(cnt_b), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("sd_a", int'(sd_a), e.sd);
      chk("sd_b", int'(sd_b), e.sd);
      chk("cnt_a", int'(cnt_a), e.cnt_a);
      chk("cnt_b", int'(cnt_b), e.cnt_b);
      chk("busy_a", int'(busy_a), e.busy);
      chk("busy_b", int'(busy_b), e.busy);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    valid = 1'b1; d = 1'b1;
    #2;
    chk("in_reset_sd", int'(sd_a), 0);
    chk("in_reset_cnt", int'(cnt_a), 0);
    valid = 1'b0;
    #10 rst_n = 1'b1;

    // 1) reset defaults, non-overlapping
    send_word(8'b0101_1011, 7);
    idle();
    // 2) overlapping
    cfg(8'b0000_1011, 4'd4, 1);
    send_word(8'b0101_1011, 7);
    idle();
    // 3) valid gap mid-pattern
    cfg(8'b0000_1011, 4'd4, 0);
    send(1); send(0);
    step(1, 0, 0, 8'h00, 4'd0, 0, 0);
    step(0, 0, 0, 8'h00, 4'd0, 0, 0);
    send(1); send(1);
    idle();
    // 4) full-length pattern, then illegal length 0
    cfg(8'b1110_0101, 4'd8, 0);
    send_word(8'b1110_0101, 8);
    cfg(8'b1110_0101, 4'd0, 0);
    send_word(8'b1110_0101, 8);
    idle();
    // 5) saturation of the 2-bit counter, clear in a match cycle
    cfg(8'b0000_0011, 4'd2, 1);
    for (int i = 0; i < 8; i++) send(1);
    step(1, 1, 0, 8'h00, 4'd0, 0, 1);
    idle();
    idle();
    // 6) asynchronous reset mid-sequence
    cfg(8'b0000_1011, 4'd4, 0);
    send(1); send(0); send(1); send(1);
    async_reset();
    send(1);
    idle();

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      bit          vv, we, clr, m;
      logic [3:0]  l;
      vv  = ($urandom_range(0, 9) < 8);
      we  = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 79) == 0);
      m   = bit'($urandom_range(0, 1));
      l   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      step(bit'($urandom_range(0, 1)), vv, we, 8'($urandom), l, m, clr);
    end
    idle();
    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
